fetch_decode_buf: RTL and testbench

//  Clocked buffer stage downstream of the fetch handshake controller; feeds the decode controller.

---
 rtl/fetch_decode_buf.sv | 189 ++++++++++++++++++
 tb/tb_fetch_decode_buf.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_buf.sv
// fetch_decode_buf
//   Clocked buffer stage between the fetch handshake controller and the decode controller.
//   Fetched {pc, instr} words arrive over a 4-phase req/ack link. Each word is queued in a
//   DEPTH-entry FIFO and replayed downstream over a second 4-phase req/ack link, which lets
//   fetch run ahead of decode by up to DEPTH words.
//
// Ports
//   clk_i      single clock, all state on the rising edge
//   rst_i      asynchronous reset, active-high
//   up_req_i   fetch request (asynchronous, synchronised here); up_data_i stable while high
//   up_data_i  fetched word {pc[31:0], instr[31:0]}
//   up_ack_o   fetch acknowledge (registered)
//   dn_req_o   decode request (registered)
//   dn_data_o  head word presented to decode (registered)
//   dn_ack_i   decode acknowledge (asynchronous, synchronised here)
//   flush_i    synchronous flush pulse, present only when FETCH_BUF_FLUSH_EN is defined
//   count_o    FIFO occupancy
//
// Configuration macro: FETCH_BUF_FLUSH_EN adds flush_i. Without it the FIFO drains only
// through downstream handshakes.

module fetch_decode_buf #(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         up_req_i,
    input  logic [DATA_W-1:0]            up_data_i,
    output logic                         up_ack_o,
    output logic                         dn_req_o,
    output logic [DATA_W-1:0]            dn_data_o,
    input  logic                         dn_ack_i,
`ifdef FETCH_BUF_FLUSH_EN
    input  logic                         flush_i,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {UIdle, UAck} up_state_e;
    typedef enum logic [1:0] {DIdle, DReq, DRet} dn_state_e;

    // ------------------------------------------------------------------
    // Handshake synchronisers; only the last stage is used by logic.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] up_sync_q, up_sync_d;
    logic [SYNC_STAGES-1:0] dn_sync_q, dn_sync_d;
    logic                   sreq, sack;

    always_comb begin
        up_sync_d = {up_sync_q[SYNC_STAGES-2:0], up_req_i};
        dn_sync_d = {dn_sync_q[SYNC_STAGES-2:0], dn_ack_i};
    end

    assign sreq = up_sync_q[SYNC_STAGES-1];
    assign sack = dn_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    up_state_e          up_state_q, up_state_d;
    dn_state_e          dn_state_q, dn_state_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [DATA_W-1:0]  dn_data_q, dn_data_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  mem_d [DEPTH];

    logic flush;
`ifdef FETCH_BUF_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Handshake event decode shared by both FSMs and the datapath
    // ------------------------------------------------------------------
    logic accept;   // upstream handshake acknowledged this edge
    logic push;     // accepted word actually written
    logic load;     // head word presented downstream this edge
    logic pop;      // head word consumed this edge
    logic keep;     // head word in flight survives a flush

    always_comb begin
        // Back-pressure uses the registered count: a push blocked by full waits one edge past
        // the pop that frees the slot.
        accept = (up_state_q == UIdle) && sreq && (count_q < FULL_CNT);
        push   = accept && !flush;
        // A flush in DIdle empties the FIFO, so nothing may be presented on that edge.
        load   = (dn_state_q == DIdle) && (count_q != '0) && !flush;
        pop    = (dn_state_q == DReq) && sack;
        keep   = (dn_state_q == DReq);
    end

    // ------------------------------------------------------------------
    // FSM state registers and datapath flops
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            up_sync_q  <= '0;
            dn_sync_q  <= '0;
            up_state_q <= UIdle;
            dn_state_q <= DIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dn_data_q  <= '0;
            mem_q      <= '{default: '0};
        end else begin
            up_sync_q  <= up_sync_d;
            dn_sync_q  <= dn_sync_d;
            up_state_q <= up_state_d;
            dn_state_q <= dn_state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            dn_data_q  <= dn_data_d;
            mem_q      <= mem_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        up_state_d = up_state_q;
        case (up_state_q)
            UIdle:   if (accept) up_state_d = UAck;
            UAck:    if (!sreq)  up_state_d = UIdle;
            default: up_state_d = UIdle;
        endcase
    end

    always_comb begin
        dn_state_d = dn_state_q;
        case (dn_state_q)
            DIdle:   if (load)  dn_state_d = DReq;
            DReq:    if (pop)   dn_state_d = DRet;
            // Wait for the ack to fall so the next request cannot be mistaken as acked.
            DRet:    if (!sack) dn_state_d = DIdle;
            default: dn_state_d = DIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        dn_data_d = dn_data_q;
        mem_d     = mem_q;

        if (push) begin
            mem_d[wr_ptr_q] = up_data_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (load) begin
            dn_data_d = mem_q[rd_ptr_q];
        end

        count_d = count_q + CW'(push) - CW'(pop);

        // Flush drops everything except a head word whose handshake is still open; if that
        // word is popped on the flush edge it leaves normally and the FIFO ends empty.
        if (flush) begin
            wr_ptr_d = rd_ptr_q + PW'(keep);
            count_d  = CW'(keep && !pop);
        end
    end

    // ------------------------------------------------------------------
    // Outputs: taken straight from flops
    // ------------------------------------------------------------------
    always_comb begin
        up_ack_o  = (up_state_q == UAck);
        dn_req_o  = (dn_state_q == DReq);
        dn_data_o = dn_data_q;
        count_o   = count_q;
    end

endmodule

// File: tb/tb_fetch_decode_buf.sv
// Self-checking bench for fetch_decode_buf. Words are queued as expected when an upstream
// handshake is started and checked in order as decode requests appear.
// Define FETCH_BUF_FLUSH_EN for both files to include the flush scenario.

module tb_fetch_decode_buf;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SYNC   = 2;
    localparam int unsigned CW     = $clog2(DEPTH + 1);
    localparam int          LIMIT  = 200;

    logic              clk = 1'b0;
    logic              rst;
    logic              up_req;
    logic [DATA_W-1:0] up_data;
    logic              up_ack;
    logic              dn_req;
    logic [DATA_W-1:0] dn_data;
    logic              dn_ack;
    logic              flush;
    logic [CW-1:0]     count;

    int n_vec = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_q [$];

    fetch_decode_buf #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .up_req_i  (up_req),
        .up_data_i (up_data),
        .up_ack_o  (up_ack),
        .dn_req_o  (dn_req),
        .dn_data_o (dn_data),
        .dn_ack_i  (dn_ack),
`ifdef FETCH_BUF_FLUSH_EN
        .flush_i   (flush),
`endif
        .count_o   (count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst     = 1'b1;
        up_req  = 1'b0;
        up_data = '0;
        dn_ack  = 1'b0;
        flush   = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Full upstream 4-phase handshake; the word becomes expected when the request starts.
    task automatic up_xfer(input logic [DATA_W-1:0] d);
        exp_q.push_back(d);
        up_data = d;
        up_req  = 1'b1;
        for (int c = 0; c < LIMIT && up_ack !== 1'b1; c++) @(negedge clk);
        n_vec++;
        if (up_ack !== 1'b1) begin
            n_err++;
            $display("FAIL up_ack_rise: got %b want 1", up_ack);
        end
        up_req = 1'b0;
        for (int c = 0; c < LIMIT && up_ack !== 1'b0; c++) @(negedge clk);
        n_vec++;
        if (up_ack !== 1'b0) begin
            n_err++;
            $display("FAIL up_ack_fall: got %b want 0", up_ack);
        end
    endtask

    // Full downstream handshake; checks the presented word against the scoreboard.
    task automatic dn_xfer();
        logic [DATA_W-1:0] want;
        for (int c = 0; c < LIMIT && dn_req !== 1'b1; c++) @(negedge clk);
        n_vec++;
        if (dn_req !== 1'b1) begin
            n_err++;
            $display("FAIL dn_req_rise: got %b want 1", dn_req);
        end else if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL dn_unexpected: got word %h with nothing expected", dn_data);
        end else begin
            want = exp_q.pop_front();
            if (dn_data !== want) begin
                n_err++;
                $display("FAIL dn_data: got %h want %h", dn_data, want);
            end
        end
        n_vec++;
        if (count > CW'(DEPTH)) begin
            n_err++;
            $display("FAIL count_bound: got %0d want <= %0d", count, DEPTH);
        end
        dn_ack = 1'b1;
        for (int c = 0; c < LIMIT && dn_req !== 1'b0; c++) @(negedge clk);
        n_vec++;
        if (dn_req !== 1'b0) begin
            n_err++;
            $display("FAIL dn_req_fall: got %b want 0", dn_req);
        end
        dn_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        up_req  = 1'b0;
        up_data = '0;
        dn_ack  = 1'b0;
        flush   = 1'b0;
        repeat (2) @(negedge clk);
        n_vec += 4;
        if (up_ack !== 1'b0) begin n_err++; $display("FAIL rst_up_ack: got %b want 0", up_ack); end
        if (dn_req !== 1'b0) begin n_err++; $display("FAIL rst_dn_req: got %b want 0", dn_req); end
        if (dn_data !== '0) begin n_err++; $display("FAIL rst_dn_data: got %h want 0", dn_data); end
        if (count !== '0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int cyc;
        logic [DATA_W-1:0] d;
        d = 64'h00000004_00000013;
        exp_q.push_back(d);
        up_data = d;
        up_req  = 1'b1;
        cyc = 0;
        while (up_ack !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (cyc != SYNC + 1) begin
            n_err++;
            $display("FAIL ack_latency: got %0d edges want %0d", cyc, SYNC + 1);
        end
        n_vec += 2;
        if (dn_req !== 1'b0) begin n_err++; $display("FAIL early_dn_req: got %b want 0", dn_req); end
        if (count !== CW'(1)) begin n_err++; $display("FAIL single_count: got %0d want 1", count); end
        up_req = 1'b0;
        @(negedge clk);
        n_vec++;
        if (dn_req !== 1'b1) begin
            n_err++;
            $display("FAIL dn_req_latency: got %b want 1", dn_req);
        end
        dn_xfer();
        for (int c = 0; c < LIMIT && up_ack !== 1'b0; c++) @(negedge clk);
        repeat (SYNC + 2) @(negedge clk);
        n_vec++;
        if (count !== '0) begin n_err++; $display("FAIL single_drain: got %0d want 0", count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 4; i++) up_xfer({32'(i * 4 + 32'h100), 32'hA000_0000 + 32'(i)});
        n_vec++;
        if (count !== CW'(4)) begin n_err++; $display("FAIL full_count: got %0d want 4", count); end
        exp_q.push_back(64'h00000110_A0000004);
        up_data = 64'h00000110_A0000004;
        up_req  = 1'b1;
        repeat (10) @(negedge clk);
        n_vec += 2;
        if (up_ack !== 1'b0) begin n_err++; $display("FAIL full_ack: got %b want 0", up_ack); end
        if (count !== CW'(4)) begin n_err++; $display("FAIL full_hold: got %0d want 4", count); end
        dn_xfer();
        for (int c = 0; c < LIMIT && up_ack !== 1'b1; c++) @(negedge clk);
        n_vec++;
        if (up_ack !== 1'b1) begin n_err++; $display("FAIL fifth_ack: got %b want 1", up_ack); end
        up_req = 1'b0;
        for (int i = 0; i < 4; i++) dn_xfer();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bp_leftover: got %0d words want 0", exp_q.size());
        end
    endtask

    task automatic test_stream();
        bit done;
        bit both_seen;
        do_reset();
        done      = 1'b0;
        both_seen = 1'b0;
        fork
            begin
                fork
                    for (int i = 0; i < 20; i++) begin
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                        up_xfer({32'(32'h1000 + i * 4), $urandom});
                    end
                    for (int i = 0; i < 20; i++) begin
                        repeat ($urandom_range(0, 4)) @(negedge clk);
                        dn_xfer();
                    end
                join
                done = 1'b1;
            end
            begin
                int prev_cnt;
                int want;
                logic prev_ack, prev_req;
                prev_cnt = int'(count);
                prev_ack = up_ack;
                prev_req = dn_req;
                for (int c = 0; c < 4000 && !done; c++) begin
                    @(negedge clk);
                    // push shows as up_ack rising, pop as dn_req falling
                    want = prev_cnt + int'(up_ack && !prev_ack) - int'(!dn_req && prev_req);
                    if (up_ack && !prev_ack && !dn_req && prev_req) both_seen = 1'b1;
                    n_vec++;
                    if (int'(count) != want || want > int'(DEPTH)) begin
                        n_err++;
                        $display("FAIL stream_count: got %0d want %0d", count, want);
                    end
                    prev_cnt = want;
                    prev_ack = up_ack;
                    prev_req = dn_req;
                end
            end
        join
        if (both_seen) $display("note: same-edge push and pop exercised");
        n_vec++;
        if (exp_q.size() != 0 || count !== '0) begin
            n_err++;
            $display("FAIL stream_drain: got %0d queued, count %0d want 0", exp_q.size(), count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        up_xfer(64'h2000);
        up_xfer(64'h2004);
        exp_q.push_back(64'h2008);
        up_data = 64'h2008;
        up_req  = 1'b1;
        for (int c = 0; c < LIMIT && up_ack !== 1'b1; c++) @(negedge clk);
        n_vec++;
        if (up_ack !== 1'b1 || dn_req !== 1'b1 || count !== CW'(3)) begin
            n_err++;
            $display("FAIL mid_setup: got ack %b req %b count %0d want 1 1 3", up_ack, dn_req, count);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (up_ack !== 1'b0 || dn_req !== 1'b0 || dn_data !== '0 || count !== '0) begin
            n_err++;
            $display("FAIL async_rst: got ack %b req %b data %h count %0d want all 0",
                     up_ack, dn_req, dn_data, count);
        end
        up_req = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_vec++;
        if (dn_req !== 1'b0 || count !== '0) begin
            n_err++;
            $display("FAIL post_rst_quiet: got req %b count %0d want 0 0", dn_req, count);
        end
        up_xfer(64'h3000_0000_0000_0001);
        dn_xfer();
    endtask

    task automatic test_ack_hold();
        logic [DATA_W-1:0] want;
        do_reset();
        up_xfer(64'h4000);
        up_xfer(64'h4004);
        for (int c = 0; c < LIMIT && dn_req !== 1'b1; c++) @(negedge clk);
        want = exp_q.pop_front();
        n_vec++;
        if (dn_req !== 1'b1 || dn_data !== want) begin
            n_err++;
            $display("FAIL hold_first: got req %b data %h want 1 %h", dn_req, dn_data, want);
        end
        dn_ack = 1'b1;
        for (int c = 0; c < LIMIT && dn_req !== 1'b0; c++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_vec++;
            if (dn_req !== 1'b0) begin
                n_err++;
                $display("FAIL hold_rereq: got %b want 0 at cycle %0d", dn_req, i);
            end
        end
        dn_ack = 1'b0;
        dn_xfer();
    endtask

`ifdef FETCH_BUF_FLUSH_EN
    task automatic test_flush();
        logic [DATA_W-1:0] head;
        do_reset();
        up_xfer(64'h5000);
        up_xfer(64'h5004);
        up_xfer(64'h5008);
        n_vec++;
        if (dn_req !== 1'b1 || count !== CW'(3)) begin
            n_err++;
            $display("FAIL flush_setup: got req %b count %0d want 1 3", dn_req, count);
        end
        head = exp_q[0];
        exp_q.delete();
        exp_q.push_back(head);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_vec++;
        if (count !== CW'(1) || dn_req !== 1'b1 || dn_data !== head) begin
            n_err++;
            $display("FAIL flush_keep: got count %0d req %b data %h want 1 1 %h",
                     count, dn_req, dn_data, head);
        end
        dn_xfer();
        n_vec++;
        if (count !== '0) begin n_err++; $display("FAIL flush_empty: got %0d want 0", count); end
        up_xfer(64'h6000);
        dn_xfer();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_reset_mid();
        test_ack_hold();
`ifdef FETCH_BUF_FLUSH_EN
        test_flush();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
